// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage pipeline.
// Selects ALU operands, evaluates the ALU, resolves branches/jumps, registers
// the EX/MEM boundary and squashes the wrong-path slots after a redirect.
module ex_stage #(
    parameter int SQUASH_SLOTS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_ctrl_regwrt,
    input  logic        in_ctrl_branch,
    input  logic        in_ctrl_btype,
    input  logic        in_ctrl_jump,
    input  logic        in_ctrl_memtoreg,
    input  logic        in_ctrl_memrd,
    input  logic        in_ctrl_memwrt,
    input  logic [2:0]  in_ctrl_aluop,
    input  logic        in_ctrl_alusrc1,
    input  logic        in_ctrl_alusrc0,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs,
    input  logic [31:0] in_rt,
    input  logic [31:0] in_x,
    input  logic [5:0]  in_rd,
    output logic        out_valid,
    output logic        out_ctrl_regwrt,
    output logic        out_ctrl_memtoreg,
    output logic        out_ctrl_memrd,
    output logic        out_ctrl_memwrt,
    output logic [31:0] out_alu,
    output logic [31:0] out_rt,
    output logic [5:0]  out_rd,
    output logic        out_redirect,
    output logic [31:0] out_target
);

    localparam int DATA_W = 32;
    localparam logic [2:0] SLOTS_INIT = 3'(SQUASH_SLOTS);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    // ALU evaluation; arithmetic wraps, compare is signed
    function automatic logic signed [DATA_W-1:0] alu_eval(
        input logic [2:0]               op,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] r;
        unique case (op)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = a ^ b;
            3'b101:  r = b;
            3'b110:  r = (a < b) ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
            default: r = -a;
        endcase
        return r;
    endfunction

    state_t              state_q;
    logic [2:0]          cnt_q;
    logic                redirect_q;
    logic [DATA_W-1:0]   target_q;

    logic                valid_q;
    logic                regwrt_q;
    logic                memtoreg_q;
    logic                memrd_q;
    logic                memwrt_q;
    logic [DATA_W-1:0]   alu_q;
    logic [DATA_W-1:0]   rt_q;
    logic [5:0]          rd_q;

    logic                     v_d;
    logic signed [DATA_W-1:0] op_a;
    logic signed [DATA_W-1:0] op_b;
    logic signed [DATA_W-1:0] alu_d;
    logic                     flag_z;
    logic                     flag_n;
    logic                     br_taken;
    logic                     jmp_taken;
    logic                     redirect_d;
    logic [DATA_W-1:0]        target_d;

    // Operand select, ALU, flags and branch/jump resolution
    always_comb begin
        v_d        = in_valid && (state_q == RUN);
        op_a       = in_ctrl_alusrc1 ? $signed(in_pc) : $signed(in_rs);
        op_b       = in_ctrl_alusrc0 ? $signed(in_x)  : $signed(in_rt);
        alu_d      = alu_eval(in_ctrl_aluop, op_a, op_b);
        flag_z     = (alu_d == '0);
        flag_n     = alu_d[DATA_W-1];
        br_taken   = v_d && in_ctrl_branch && (in_ctrl_btype ? flag_n : flag_z);
        jmp_taken  = v_d && in_ctrl_jump;
        redirect_d = br_taken || jmp_taken;
        // Jump wins when both branch and jump are flagged
        target_d   = jmp_taken ? in_rs : (in_pc + in_x);
    end

    // EX/MEM boundary register: control gated by effective valid
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            regwrt_q   <= 1'b0;
            memtoreg_q <= 1'b0;
            memrd_q    <= 1'b0;
            memwrt_q   <= 1'b0;
            alu_q      <= '0;
            rt_q       <= '0;
            rd_q       <= '0;
        end else begin
            valid_q    <= v_d;
            regwrt_q   <= in_ctrl_regwrt   & v_d;
            memtoreg_q <= in_ctrl_memtoreg & v_d;
            memrd_q    <= in_ctrl_memrd    & v_d;
            memwrt_q   <= in_ctrl_memwrt   & v_d;
            alu_q      <= alu_d;
            rt_q       <= in_rt;
            rd_q       <= in_rd;
        end
    end

    // Redirect/squash FSM with registered redirect pulse and target
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            cnt_q      <= '0;
            redirect_q <= 1'b0;
            target_q   <= '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (redirect_d) begin
                        state_q    <= SQUASH;
                        cnt_q      <= SLOTS_INIT;
                        redirect_q <= 1'b1;
                        target_q   <= target_d;
                    end else begin
                        redirect_q <= 1'b0;
                    end
                end
                default: begin
                    // Slots are counted in cycles, independent of in_valid
                    redirect_q <= 1'b0;
                    cnt_q      <= cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_q <= RUN;
                    end
                end
            endcase
        end
    end

    assign out_valid         = valid_q;
    assign out_ctrl_regwrt   = regwrt_q;
    assign out_ctrl_memtoreg = memtoreg_q;
    assign out_ctrl_memrd    = memrd_q;
    assign out_ctrl_memwrt   = memwrt_q;
    assign out_alu           = alu_q;
    assign out_rt            = rt_q;
    assign out_rd            = rd_q;
    assign out_redirect      = redirect_q;
    assign out_target        = target_q;

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed steps plus randomized traffic, checked
// against a cycle-level behavioural model of the execute stage.
module tb_ex_stage;

    localparam int SLOTS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ctrl_regwrt, in_ctrl_branch, in_ctrl_btype, in_ctrl_jump;
    logic        in_ctrl_memtoreg, in_ctrl_memrd, in_ctrl_memwrt;
    logic [2:0]  in_ctrl_aluop;
    logic        in_ctrl_alusrc1, in_ctrl_alusrc0;
    logic [31:0] in_pc, in_rs, in_rt, in_x;
    logic [5:0]  in_rd;
    logic        out_valid, out_ctrl_regwrt, out_ctrl_memtoreg, out_ctrl_memrd, out_ctrl_memwrt;
    logic [31:0] out_alu, out_rt;
    logic [5:0]  out_rd;
    logic        out_redirect;
    logic [31:0] out_target;

    int total = 0;
    int fails = 0;

    // Model state
    int          sq_left = 0;
    logic        e_valid = 0, e_regwrt = 0, e_memtoreg = 0, e_memrd = 0, e_memwrt = 0;
    logic [31:0] e_alu = 0, e_rt = 0, e_target = 0;
    logic [5:0]  e_rd = 0;
    logic        e_redirect = 0;

    ex_stage #(.SQUASH_SLOTS(SLOTS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .in_ctrl_regwrt(in_ctrl_regwrt), .in_ctrl_branch(in_ctrl_branch),
        .in_ctrl_btype(in_ctrl_btype), .in_ctrl_jump(in_ctrl_jump),
        .in_ctrl_memtoreg(in_ctrl_memtoreg), .in_ctrl_memrd(in_ctrl_memrd),
        .in_ctrl_memwrt(in_ctrl_memwrt), .in_ctrl_aluop(in_ctrl_aluop),
        .in_ctrl_alusrc1(in_ctrl_alusrc1), .in_ctrl_alusrc0(in_ctrl_alusrc0),
        .in_pc(in_pc), .in_rs(in_rs), .in_rt(in_rt), .in_x(in_x), .in_rd(in_rd),
        .out_valid(out_valid), .out_ctrl_regwrt(out_ctrl_regwrt),
        .out_ctrl_memtoreg(out_ctrl_memtoreg), .out_ctrl_memrd(out_ctrl_memrd),
        .out_ctrl_memwrt(out_ctrl_memwrt), .out_alu(out_alu), .out_rt(out_rt),
        .out_rd(out_rd), .out_redirect(out_redirect), .out_target(out_target)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int signed sa, sb;
        sa = a;
        sb = b;
        if (op == 3'd0) return a + b;
        if (op == 3'd1) return a - b;
        if (op == 3'd2) return a & b;
        if (op == 3'd3) return a | b;
        if (op == 3'd4) return a ^ b;
        if (op == 3'd5) return b;
        if (op == 3'd6) return (sa < sb) ? 32'd1 : 32'd0;
        return 32'd0 - a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        assert (act === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, act, exp);
        end
    endtask

    task automatic clear_in();
        in_valid = 1'b0;
        in_ctrl_regwrt = 0; in_ctrl_branch = 0; in_ctrl_btype = 0; in_ctrl_jump = 0;
        in_ctrl_memtoreg = 0; in_ctrl_memrd = 0; in_ctrl_memwrt = 0;
        in_ctrl_aluop = 3'd0; in_ctrl_alusrc1 = 0; in_ctrl_alusrc0 = 0;
        in_pc = 0; in_rs = 0; in_rt = 0; in_x = 0; in_rd = 0;
    endtask

    // Advance the model by one clock using the current inputs, then clock the DUT and compare
    task automatic step();
        logic [31:0] a, b, r;
        logic v, tk;
        if (rst) begin
            e_valid = 0; e_regwrt = 0; e_memtoreg = 0; e_memrd = 0; e_memwrt = 0;
            e_alu = 0; e_rt = 0; e_rd = 0; e_redirect = 0; e_target = 0;
            sq_left = 0;
        end else begin
            v = in_valid && (sq_left == 0);
            a = in_ctrl_alusrc1 ? in_pc : in_rs;
            b = in_ctrl_alusrc0 ? in_x : in_rt;
            r = ref_alu(in_ctrl_aluop, a, b);
            tk = v && (in_ctrl_jump || (in_ctrl_branch && (in_ctrl_btype ? r[31] : (r == 0))));
            e_valid = v;
            e_regwrt = in_ctrl_regwrt && v;
            e_memtoreg = in_ctrl_memtoreg && v;
            e_memrd = in_ctrl_memrd && v;
            e_memwrt = in_ctrl_memwrt && v;
            e_alu = r; e_rt = in_rt; e_rd = in_rd;
            e_redirect = 0;
            if (sq_left > 0) sq_left--;
            else if (tk) begin
                sq_left = SLOTS;
                e_redirect = 1;
                e_target = in_ctrl_jump ? in_rs : in_pc + in_x;
            end
        end
        @(posedge clk);
        #1;
        chk("valid", 32'(out_valid), 32'(e_valid));
        chk("regwrt", 32'(out_ctrl_regwrt), 32'(e_regwrt));
        chk("memtoreg", 32'(out_ctrl_memtoreg), 32'(e_memtoreg));
        chk("memrd", 32'(out_ctrl_memrd), 32'(e_memrd));
        chk("memwrt", 32'(out_ctrl_memwrt), 32'(e_memwrt));
        chk("alu", out_alu, e_alu);
        chk("rt", out_rt, e_rt);
        chk("rd", 32'(out_rd), 32'(e_rd));
        chk("redirect", 32'(out_redirect), 32'(e_redirect));
        chk("target", out_target, e_target);
    endtask

    initial begin
        logic [31:0] sweep [8];
        sweep = '{32'h80000000, 32'h7FFFFFFE, 32'h00000001, 32'h7FFFFFFF,
                  32'h7FFFFFFE, 32'h00000001, 32'h00000000, 32'h80000001};
        clear_in();

        // Reset state
        rst = 1; step(); step();
        chk("rst_valid", 32'(out_valid), 32'd0);
        rst = 0;

        // ALU sweep
        for (int op = 0; op < 8; op++) begin
            clear_in();
            in_valid = 1; in_rs = 32'h7FFFFFFF; in_rt = 32'h1; in_ctrl_aluop = 3'(op); in_rd = 6'(op + 1);
            step();
            chk("sweep_const", out_alu, sweep[op]);
        end

        // Taken BEQ, then two squashed slots carrying memwrt, then a valid slot
        clear_in();
        in_valid = 1; in_rs = 5; in_rt = 5; in_ctrl_aluop = 3'd1; in_ctrl_branch = 1;
        in_pc = 32'h100; in_x = 32'h20;
        step();
        chk("beq_redirect", 32'(out_redirect), 32'd1);
        chk("beq_target", out_target, 32'h120);
        clear_in();
        in_valid = 1; in_ctrl_memwrt = 1; in_rt = 32'hAB;
        step();
        chk("beq_slot1_valid", 32'(out_valid), 32'd0);
        chk("beq_slot1_redirect", 32'(out_redirect), 32'd0);
        step();
        chk("beq_slot2_memwrt", 32'(out_ctrl_memwrt), 32'd0);
        step();
        chk("beq_after_valid", 32'(out_valid), 32'd1);

        // Not-taken BLT
        clear_in();
        in_valid = 1; in_rs = 3; in_rt = 1; in_ctrl_aluop = 3'd1; in_ctrl_branch = 1; in_ctrl_btype = 1;
        step();
        chk("blt_no_redirect", 32'(out_redirect), 32'd0);
        step();
        chk("blt_still_valid", 32'(out_valid), 32'd1);

        // Jump with branch set; taken branch in the following slot is ignored
        clear_in();
        in_valid = 1; in_rs = 32'h400; in_rt = 32'h400; in_ctrl_aluop = 3'd1;
        in_ctrl_jump = 1; in_ctrl_branch = 1; in_pc = 32'h80; in_x = 32'h4;
        step();
        chk("jmp_target", out_target, 32'h400);
        clear_in();
        in_valid = 1; in_rs = 7; in_rt = 7; in_ctrl_aluop = 3'd1; in_ctrl_branch = 1; in_pc = 32'h200;
        step();
        chk("slot_branch_ignored", 32'(out_redirect), 32'd0);
        chk("slot_target_held", out_target, 32'h400);
        clear_in();
        step();

        // Reset mid-squash
        in_valid = 1; in_rs = 32'h300; in_ctrl_jump = 1; in_ctrl_regwrt = 1;
        step();
        clear_in();
        in_valid = 1; rst = 1;
        step();
        chk("rst_mid_target", out_target, 32'd0);
        rst = 0;
        in_valid = 1; in_ctrl_regwrt = 1; in_rs = 9; in_rt = 4; in_rd = 6'd12;
        step();
        chk("post_rst_valid", 32'(out_valid), 32'd1);

        // Invalid input with regwrt and jump
        clear_in();
        in_ctrl_regwrt = 1; in_ctrl_jump = 1; in_rs = 32'h500;
        step();
        chk("inv_redirect", 32'(out_redirect), 32'd0);
        chk("inv_regwrt", 32'(out_ctrl_regwrt), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            in_valid = ($urandom_range(0, 9) != 0);
            in_ctrl_regwrt = 1'($urandom); in_ctrl_memtoreg = 1'($urandom);
            in_ctrl_memrd = 1'($urandom); in_ctrl_memwrt = 1'($urandom);
            in_ctrl_branch = ($urandom_range(0, 2) == 0);
            in_ctrl_btype = 1'($urandom);
            in_ctrl_jump = ($urandom_range(0, 7) == 0);
            in_ctrl_aluop = 3'($urandom);
            in_ctrl_alusrc1 = 1'($urandom); in_ctrl_alusrc0 = 1'($urandom);
            in_pc = $urandom; in_rs = $urandom; in_x = $urandom;
            in_rt = ($urandom_range(0, 3) == 0) ? in_rs : $urandom;
            in_rd = 6'($urandom);
            step();
        end
        rst = 0;

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
